// File: rtl/stage6wb_if.sv
// Write-back stage bundle: upstream result offer, register-file write port and retire status.
interface stage6wb_if;
    logic        enable;
    logic [11:0] pc_in;
    logic        rd_we;
    logic [3:0]  rd_addr;
    logic [23:0] rd_data;
    logic        halt_in;
    logic        stall_out;
    logic        rf_we;
    logic [3:0]  rf_addr;
    logic [23:0] rf_data;
    logic        rf_ready;
    logic        retire_valid;
    logic [11:0] retire_pc;
    logic [15:0] retire_count;
    logic        halted;

    modport master (
        output enable, pc_in, rd_we, rd_addr, rd_data, halt_in, rf_ready,
        input  stall_out, rf_we, rf_addr, rf_data, retire_valid, retire_pc, retire_count, halted
    );

    modport slave (
        input  enable, pc_in, rd_we, rd_addr, rd_data, halt_in, rf_ready,
        output stall_out, rf_we, rf_addr, rf_data, retire_valid, retire_pc, retire_count, halted
    );
endinterface

// File: rtl/stage6wb.sv
// Write-back stage: 2-entry skid FIFO feeding the register-file write port, in-order retire, halt drain.
// Define STAGE6WB_RETIRE_CNT_EN to implement the 16-bit retire counter; otherwise retire_count is 0.
module stage6wb (
    input  logic      clk,
    input  logic      rst,
    stage6wb_if.slave bus
);
    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    typedef struct packed {
        logic [11:0] pc;
        logic        we;
        logic [3:0]  addr;
        logic [23:0] data;
        logic        halt;
    } entry_t;

    state_t      state;
    state_t      state_next;
    entry_t      fifo [2];
    entry_t      head;
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  cnt;
    logic        stall;
    logic        push;
    logic        pop;
    logic        write_head;
    logic        retire_valid_q;
    logic [11:0] retire_pc_q;

    assign head       = fifo[rd_ptr];
    assign stall      = (cnt == 2'd2) || (state != RUN);
    assign push       = bus.enable && !stall;
    // r0 writes are dropped at the port but still pop and retire normally
    assign write_head = (cnt != 2'd0) && head.we && (head.addr != 4'd0);
    assign pop        = (cnt != 2'd0) && (!write_head || bus.rf_ready);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // No pushes happen in DRAIN, so the sole remaining entry there is the halt itself
    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (push && bus.halt_in) state_next = DRAIN;
            DRAIN:   if (pop && (cnt == 2'd1) && head.halt) state_next = HALTED;
            HALTED:  state_next = HALTED;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo[wr_ptr] <= '{pc: bus.pc_in, we: bus.rd_we, addr: bus.rd_addr,
                              data: bus.rd_data, halt: bus.halt_in};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retire_valid_q <= 1'b0;
            retire_pc_q    <= 12'd0;
        end else begin
            retire_valid_q <= pop;
            if (pop) retire_pc_q <= head.pc;
        end
    end

`ifdef STAGE6WB_RETIRE_CNT_EN
    logic [15:0] retire_count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retire_count_q <= 16'd0;
        end else if (pop) begin
            retire_count_q <= retire_count_q + 16'd1;
        end
    end

    assign bus.retire_count = retire_count_q;
`else
    assign bus.retire_count = 16'd0;
`endif

    assign bus.stall_out    = stall;
    assign bus.rf_we        = write_head;
    assign bus.rf_addr      = (cnt != 2'd0) ? head.addr : 4'd0;
    assign bus.rf_data      = (cnt != 2'd0) ? head.data : 24'd0;
    assign bus.retire_valid = retire_valid_q;
    assign bus.retire_pc    = retire_pc_q;
    assign bus.halted       = (state == HALTED);
endmodule

// File: tb/tb_stage6wb.sv
// Randomised scoreboard bench for stage6wb: a queue model predicts FIFO contents, stalls and retire order.
`timescale 1ns/1ps
module tb_stage6wb;
    logic clk = 1'b0;
    logic rst;

    stage6wb_if bus();

    stage6wb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

`ifdef STAGE6WB_RETIRE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    localparam int WRAP_N = CNT_EN ? 65536 : 16;
    localparam int M_RUN = 0, M_DRAIN = 1, M_HALTED = 2;

    typedef struct {
        logic [11:0] pc;
        logic        we;
        logic [3:0]  addr;
        logic [23:0] data;
    } ent_t;

    ent_t        model_q[$];
    logic [11:0] exp_q[$];
    int          mode;
    logic [15:0] model_count;
    logic        model_retired;
    logic        m_stall;
    logic        m_push;
    logic        m_pop;
    int          checks = 0;
    int          failures = 0;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // Reference model: the stage is an ordered queue of at most two results; a halt closes intake
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            model_q.delete();
            exp_q.delete();
            mode          = M_RUN;
            model_count   = 16'd0;
            model_retired = 1'b0;
        end else begin
            m_stall = (model_q.size() >= 2) || (mode != M_RUN);
            m_push  = bus.enable && !m_stall;
            m_pop   = 1'b0;
            if (model_q.size() > 0)
                m_pop = !(model_q[0].we && model_q[0].addr != 4'd0) || bus.rf_ready;
            model_retired = m_pop;
            if (m_pop) begin
                void'(model_q.pop_front());
                if (CNT_EN) model_count = model_count + 16'd1;
            end
            if (m_push) begin
                model_q.push_back('{pc: bus.pc_in, we: bus.rd_we, addr: bus.rd_addr, data: bus.rd_data});
                exp_q.push_back(bus.pc_in);
                if (bus.halt_in) mode = M_DRAIN;
            end
            if (mode == M_DRAIN && model_q.size() == 0) mode = M_HALTED;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            check_output("stall_out", 32'(bus.stall_out), 32'((model_q.size() >= 2) || (mode != M_RUN)));
            if (model_q.size() > 0) begin
                check_output("rf_we", 32'(bus.rf_we), 32'(model_q[0].we && model_q[0].addr != 4'd0));
                check_output("rf_addr", 32'(bus.rf_addr), 32'(model_q[0].addr));
                check_output("rf_data", 32'(bus.rf_data), 32'(model_q[0].data));
            end else begin
                check_output("rf_we_idle", 32'(bus.rf_we), 32'd0);
                check_output("rf_addr_idle", 32'(bus.rf_addr), 32'd0);
                check_output("rf_data_idle", 32'(bus.rf_data), 32'd0);
            end
            check_output("halted", 32'(bus.halted), 32'(mode == M_HALTED));
            check_output("retire_count", 32'(bus.retire_count), 32'(model_count));
            check_output("retire_valid", 32'(bus.retire_valid), 32'(model_retired));
            if (bus.retire_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL retire_pc_unexpected actual=0x%0h expected=none", bus.retire_pc);
                end else begin
                    check_output("retire_pc", 32'(bus.retire_pc), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic apply_stimulus(input logic en, input logic [11:0] pc, input logic we,
                                  input logic [3:0] addr, input logic [23:0] data,
                                  input logic halt, input logic ready);
        bus.enable   = en;
        bus.pc_in    = pc;
        bus.rd_we    = we;
        bus.rd_addr  = addr;
        bus.rd_data  = data;
        bus.halt_in  = halt;
        bus.rf_ready = ready;
        @(negedge clk);
    endtask

    task automatic send(input logic [11:0] pc, input logic we, input logic [3:0] addr,
                        input logic [23:0] data, input logic halt, input logic ready);
        logic accepted = 1'b0;
        for (int t = 0; t < 20 && !accepted; t++) begin
            accepted = !bus.stall_out;
            apply_stimulus(1'b1, pc, we, addr, data, halt, ready);
        end
        if (!accepted) check_output("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n, input logic ready);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 12'd0, 1'b0, 4'd0, 24'd0, 1'b0, ready);
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        check_output("rst_stall_out", 32'(bus.stall_out), 32'd0);
        check_output("rst_rf_we", 32'(bus.rf_we), 32'd0);
        check_output("rst_rf_addr", 32'(bus.rf_addr), 32'd0);
        check_output("rst_rf_data", 32'(bus.rf_data), 32'd0);
        check_output("rst_retire_valid", 32'(bus.retire_valid), 32'd0);
        check_output("rst_retire_pc", 32'(bus.retire_pc), 32'd0);
        check_output("rst_retire_count", 32'(bus.retire_count), 32'd0);
        check_output("rst_halted", 32'(bus.halted), 32'd0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        idle(1, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b0;
        bus.enable = 1'b0; bus.pc_in = '0; bus.rd_we = 1'b0; bus.rd_addr = '0;
        bus.rd_data = '0; bus.halt_in = 1'b0; bus.rf_ready = 1'b1;
        @(negedge clk);
        do_reset();

        for (int i = 0; i < 4; i++)
            apply_stimulus(1'b1, 12'(12'h010 + i), 1'b1, 4'(i + 1), 24'(24'hA0000 + i), 1'b0, 1'b1);
        idle(3, 1'b1);
        check_output("count_after_stream", 32'(bus.retire_count), CNT_EN ? 32'd4 : 32'd0);

        // Backpressure: third offer must be held while two writes sit unretired
        apply_stimulus(1'b1, 12'h018, 1'b1, 4'd6, 24'h111111, 1'b0, 1'b0);
        apply_stimulus(1'b1, 12'h019, 1'b1, 4'd7, 24'h222222, 1'b0, 1'b0);
        check_output("stall_after_two", 32'(bus.stall_out), 32'd1);
        for (int i = 0; i < 3; i++)
            apply_stimulus(1'b1, 12'h01A, 1'b1, 4'd8, 24'h333333, 1'b0, 1'b0);
        check_output("head_stable_addr", 32'(bus.rf_addr), 32'd6);
        send(12'h01A, 1'b1, 4'd8, 24'h333333, 1'b0, 1'b1);
        idle(3, 1'b1);

        send(12'h020, 1'b1, 4'd0, 24'h123456, 1'b0, 1'b1);
        idle(2, 1'b1);

        send(12'h02F, 1'b1, 4'd5, 24'h555555, 1'b0, 1'b0);
        send(12'h030, 1'b0, 4'd0, 24'd0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            apply_stimulus(1'b1, 12'h031, 1'b1, 4'd9, 24'h999999, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++)
            apply_stimulus(1'b1, 12'h032, 1'b1, 4'd9, 24'h999999, 1'b0, 1'b1);
        check_output("halted_after_drain", 32'(bus.halted), 32'd1);
        do_reset();

        for (int i = 0; i < 400; i++) begin
            apply_stimulus(1'($urandom_range(0, 3) != 0), 12'($urandom), 1'($urandom),
                           4'($urandom), 24'($urandom), 1'($urandom_range(0, 49) == 0),
                           1'($urandom_range(0, 3) != 0));
            if (mode == M_HALTED) do_reset();
        end
        idle(4, 1'b1);

        do_reset();
        for (int i = 0; i < WRAP_N; i++)
            apply_stimulus(1'b1, 12'(i), 1'b1, 4'(i % 15 + 1), 24'(i), 1'b0, 1'b1);
        idle(3, 1'b1);
        check_output("count_wrapped", 32'(bus.retire_count), CNT_EN ? 32'd0 : 32'd0);

        apply_stimulus(1'b1, 12'h040, 1'b1, 4'd3, 24'hABCDEF, 1'b0, 1'b0);
        apply_stimulus(1'b1, 12'h041, 1'b1, 4'd4, 24'hFEDCBA, 1'b0, 1'b0);
        do_reset();
        idle(3, 1'b1);
        check_output("post_reset_rf_we", 32'(bus.rf_we), 32'd0);
        check_output("post_reset_stall", 32'(bus.stall_out), 32'd0);
        check_output("post_reset_halted", 32'(bus.halted), 32'd0);
        check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
